// File: rtl/fifo_byte_serializer_pkg.sv
// Shared state encoding and sizing constants for the FIFO-to-serial byte serializer.
// Build with SERIALIZER_PARITY_EN defined to append an even-parity bit after each word.
package fifo_byte_serializer_pkg;

    localparam int DEFAULT_DATA_W = 8;
    localparam int DEFAULT_CNT_W  = $clog2(DEFAULT_DATA_W) + 1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        LOAD,
        SHIFT
`ifdef SERIALIZER_PARITY_EN
        ,
        PARITY
`endif
    } state_t;

    // The counter needs one spare bit so it can step past the last index.
    function automatic int cnt_width(input int data_w);
        return $clog2(data_w) + 1;
    endfunction

endpackage

// File: rtl/fifo_byte_serializer_shift_reg.sv
// Word shift register plus bit counter for the serializer datapath.
// Built the same way with or without SERIALIZER_PARITY_EN; the parity bit lives in the top.
module serializer_shift_reg
    import fifo_byte_serializer_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load,
    input  logic              shift,
    input  logic [DATA_W-1:0] load_data,
    output logic              cur_bit,
    output logic              last_bit
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [DATA_W-1:0] sr;
    logic [CNT_W-1:0]  count;

    // The outgoing bit always sits at the MSB or LSB end; zeros backfill as it empties.
    always_ff @(posedge clock) begin
        if (reset) begin
            sr    <= '0;
            count <= '0;
        end else if (load) begin
            sr    <= load_data;
            count <= '0;
        end else if (shift) begin
            sr    <= (MSB_FIRST != 0) ? {sr[DATA_W-2:0], 1'b0} : {1'b0, sr[DATA_W-1:1]};
            count <= count + CNT_ONE;
        end
    end

    assign cur_bit  = (MSB_FIRST != 0) ? sr[DATA_W-1] : sr[0];
    assign last_bit = (count == LAST_IDX);

endmodule

// File: rtl/fifo_byte_serializer.sv
// Pops words from an upstream FIFO and streams them out bit by bit under valid/ready.
// SERIALIZER_PARITY_EN adds a PARITY state sending the even parity of each word last.
module fifo_byte_serializer
    import fifo_byte_serializer_pkg::*;
#(
    parameter int DATA_W    = DEFAULT_DATA_W,
    parameter int MSB_FIRST = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_read_en,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic              busy,
    output logic              byte_done
);

    state_t state;
    state_t state_next;
    logic   cur_bit;
    logic   last_bit;
    logic   load;
    logic   shift;
    logic   byte_end;

    serializer_shift_reg #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST),
        .CNT_W     (cnt_width(DATA_W))
    ) u_shift_reg (
        .clock     (clock),
        .reset     (reset),
        .load      (load),
        .shift     (shift),
        .load_data (fifo_data),
        .cur_bit   (cur_bit),
        .last_bit  (last_bit)
    );

`ifdef SERIALIZER_PARITY_EN
    logic parity_bit;

    always_ff @(posedge clock) begin
        if (reset)
            parity_bit <= 1'b0;
        else if (load)
            parity_bit <= ^fifo_data;
    end
`endif

    always_ff @(posedge clock) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // en is only consulted when leaving IDLE or at a byte boundary, so a byte never aborts.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (en && !fifo_empty) state_next = REQ;
            REQ:   state_next = LOAD;
            LOAD:  state_next = SHIFT;
            SHIFT: begin
                if (bit_ready && last_bit) begin
`ifdef SERIALIZER_PARITY_EN
                    state_next = PARITY;
`else
                    state_next = (en && !fifo_empty) ? REQ : IDLE;
`endif
                end
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: if (bit_ready) state_next = (en && !fifo_empty) ? REQ : IDLE;
`endif
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fifo_read_en = 1'b0;
        bit_valid    = 1'b0;
        bit_out      = 1'b0;
        load         = 1'b0;
        shift        = 1'b0;
        byte_end     = 1'b0;
        busy         = (state != IDLE);
        case (state)
            REQ:  fifo_read_en = 1'b1;
            LOAD: load = 1'b1;
            SHIFT: begin
                bit_valid = 1'b1;
                bit_out   = cur_bit;
                shift     = bit_ready;
`ifndef SERIALIZER_PARITY_EN
                byte_end  = bit_ready && last_bit;
`endif
            end
`ifdef SERIALIZER_PARITY_EN
            PARITY: begin
                bit_valid = 1'b1;
                bit_out   = parity_bit;
                byte_end  = bit_ready;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset)
            byte_done <= 1'b0;
        else
            byte_done <= byte_end;
    end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Testbench for fifo_byte_serializer: a queue-based FIFO model feeds the DUT and an
// expected bit stream is built from each pushed word (plus parity when SERIALIZER_PARITY_EN).
module tb_fifo_byte_serializer;

    localparam int DATA_W    = 8;
    localparam int MSB_FIRST = 1;
`ifdef SERIALIZER_PARITY_EN
    localparam int BITS_PER_WORD = DATA_W + 1;
`else
    localparam int BITS_PER_WORD = DATA_W;
`endif
    localparam int TIMEOUT = 3000;

    logic              clock      = 1'b0;
    logic              reset      = 1'b1;
    logic              en         = 1'b0;
    logic              fifo_empty = 1'b1;
    logic              bit_ready  = 1'b0;
    logic [DATA_W-1:0] fifo_data  = '0;
    logic              fifo_read_en;
    logic              bit_out;
    logic              bit_valid;
    logic              busy;
    logic              byte_done;

    int compared   = 0;
    int mismatched = 0;

    logic [DATA_W-1:0] fifo_q[$];
    logic              exp_bits[$];
    logic              obs_bits[$];

    int   cyc           = 0;
    int   pops          = 0;
    int   done_cnt      = 0;
    int   bad_pops      = 0;
    int   hold_viol     = 0;
    int   first_pop_cyc = -1;
    int   last_xfer_cyc = -1;
    int   t;
    logic saw_read_en   = 1'b0;
    logic saw_busy      = 1'b0;
    logic prev_hold     = 1'b0;
    logic prev_bit      = 1'b0;
    logic fifo_pop_seen = 1'b0;

    fifo_byte_serializer #(
        .DATA_W    (DATA_W),
        .MSB_FIRST (MSB_FIRST)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .en           (en),
        .fifo_empty   (fifo_empty),
        .fifo_data    (fifo_data),
        .fifo_read_en (fifo_read_en),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .bit_ready    (bit_ready),
        .busy         (busy),
        .byte_done    (byte_done)
    );

    always #5 clock = ~clock;

    // Upstream FIFO: a pop seen at an edge presents the next word just after that edge.
    initial forever begin
        @(posedge clock);
        fifo_pop_seen = fifo_read_en;
        #1;
        if (fifo_pop_seen && fifo_q.size() > 0)
            fifo_data = fifo_q.pop_front();
        fifo_empty = (fifo_q.size() == 0);
    end

    // Records every transfer and pop, and watches the hold rule while the sink stalls.
    initial forever begin
        @(negedge clock);
        #1;
        cyc++;
        if (!reset) begin
            if (bit_valid && bit_ready) begin
                obs_bits.push_back(bit_out);
                last_xfer_cyc = cyc;
            end
            if (fifo_read_en) begin
                pops++;
                if (first_pop_cyc < 0) first_pop_cyc = cyc;
            end
            if (fifo_read_en && fifo_empty) bad_pops++;
            if (prev_hold && (!bit_valid || bit_out !== prev_bit)) hold_viol++;
        end
        if (byte_done)    done_cnt++;
        if (fifo_read_en) saw_read_en = 1'b1;
        if (busy)         saw_busy = 1'b1;
        prev_hold = bit_valid && !bit_ready && !reset;
        prev_bit  = bit_out;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] word);
        fifo_q.push_back(word);
        for (int i = 0; i < DATA_W; i++)
            exp_bits.push_back((MSB_FIRST != 0) ? word[DATA_W-1-i] : word[i]);
`ifdef SERIALIZER_PARITY_EN
        exp_bits.push_back(^word);
`endif
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic waitDrain(input string tag, input bit rand_ready);
        int w;
        w = 0;
        while ((obs_bits.size() < exp_bits.size() || busy || fifo_q.size() != 0) && w < TIMEOUT) begin
            @(negedge clock);
            if (rand_ready) bit_ready = 1'($urandom_range(0, 1));
            w++;
        end
        bit_ready = 1'b1;
        tick(2);
        checkOutput({tag, "_drain_in_time"}, 32'(w < TIMEOUT), 32'd1);
    endtask

    task automatic compareStream(input string tag);
        checkOutput({tag, "_bit_count"}, obs_bits.size(), exp_bits.size());
        for (int i = 0; i < exp_bits.size(); i++)
            checkOutput($sformatf("%s_bit%0d", tag, i),
                        (i < obs_bits.size()) ? 32'(obs_bits[i]) : 32'hx, 32'(exp_bits[i]));
        obs_bits.delete();
        exp_bits.delete();
    endtask

    task automatic waitBits(input string tag, input int n);
        t = 0;
        while (obs_bits.size() < n && t < TIMEOUT) begin
            @(negedge clock);
            t++;
        end
        checkOutput({tag, "_reached"}, 32'(t < TIMEOUT), 32'd1);
    endtask

    initial begin
        $display("[TB] starting fifo_byte_serializer bench, %0d bits per word", BITS_PER_WORD);

        tick(3);
        checkOutput("reset_fifo_read_en", fifo_read_en, 0);
        checkOutput("reset_bit_valid", bit_valid, 0);
        checkOutput("reset_bit_out", bit_out, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_byte_done", byte_done, 0);
        reset = 1'b0;
        tick(1);

        en = 1'b1;
        bit_ready = 1'b1;
        pops = 0;
        done_cnt = 0;
        applyStimulus(8'hA5);
        waitDrain("a5", 1'b0);
        checkOutput("a5_pops", pops, 1);
        checkOutput("a5_byte_done", done_cnt, 1);
        compareStream("a5");

        pops = 0;
        done_cnt = 0;
        first_pop_cyc = -1;
        applyStimulus(8'h3C);
        applyStimulus(8'h81);
        waitDrain("b2b", 1'b0);
        checkOutput("b2b_pops", pops, 2);
        checkOutput("b2b_byte_done", done_cnt, 2);
        checkOutput("b2b_span_cycles", last_xfer_cyc - first_pop_cyc + 1, 2 * (BITS_PER_WORD + 2));
        compareStream("b2b");

        applyStimulus(8'hF0);
        waitBits("hold", 4);
        bit_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            checkOutput($sformatf("hold_valid_c%0d", k), bit_valid, 1);
            checkOutput($sformatf("hold_bit_c%0d", k), bit_out, 0);
            @(negedge clock);
            if (k == 2) bit_ready = 1'b1;
        end
        waitDrain("hold", 1'b0);
        compareStream("hold");

        saw_read_en = 1'b0;
        saw_busy = 1'b0;
        tick(50);
        checkOutput("empty_read_en_seen", saw_read_en, 0);
        checkOutput("empty_busy_seen", saw_busy, 0);

        pops = 0;
        done_cnt = 0;
        applyStimulus(8'h96);
        applyStimulus(8'h69);
        waitBits("endrop", 3);
        en = 1'b0;
        t = 0;
        while (busy && t < TIMEOUT) begin
            @(negedge clock);
            t++;
        end
        tick(3);
        checkOutput("endrop_idle_in_time", 32'(t < TIMEOUT), 32'd1);
        checkOutput("endrop_bits_first", obs_bits.size(), BITS_PER_WORD);
        checkOutput("endrop_pops_first", pops, 1);
        checkOutput("endrop_done_first", done_cnt, 1);
        en = 1'b1;
        waitDrain("endrop", 1'b0);
        checkOutput("endrop_pops_total", pops, 2);
        compareStream("endrop");

        pops = 0;
        applyStimulus(8'hFF);
        waitBits("rst_mid", 3);
        reset = 1'b1;
        bit_ready = 1'b0;
        tick(1);
        reset = 1'b0;
        checkOutput("rst_mid_bit_valid", bit_valid, 0);
        checkOutput("rst_mid_busy", busy, 0);
        checkOutput("rst_mid_bit_out", bit_out, 0);
        obs_bits.delete();
        exp_bits.delete();
        bit_ready = 1'b1;
        tick(20);
        checkOutput("rst_mid_pops", pops, 1);
        checkOutput("rst_mid_no_bits", obs_bits.size(), 0);
        applyStimulus(8'h5A);
        waitDrain("post_rst", 1'b0);
        checkOutput("post_rst_pops", pops, 2);
        compareStream("post_rst");

        pops = 0;
        done_cnt = 0;
        for (int i = 0; i < 6; i++)
            applyStimulus(DATA_W'($urandom));
        waitDrain("rand", 1'b1);
        checkOutput("rand_pops", pops, 6);
        checkOutput("rand_byte_done", done_cnt, 6);
        compareStream("rand");

`ifdef SERIALIZER_PARITY_EN
        applyStimulus(8'h07);
        applyStimulus(8'h03);
        waitDrain("parity", 1'b0);
        checkOutput("parity_07", (obs_bits.size() > 8) ? 32'(obs_bits[8]) : 32'hx, 32'd1);
        checkOutput("parity_03", (obs_bits.size() > 17) ? 32'(obs_bits[17]) : 32'hx, 32'd0);
        compareStream("parity");
`endif

        checkOutput("hold_violations", hold_viol, 0);
        checkOutput("pop_while_empty", bad_pops, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fifo_byte_serializer.md
FIFO_BYTE_SERIALIZER -- requirements
Module: fifo_byte_serializer

Interface
REQ-001 SHALL have parameter DATA_W, default 8, bits per FIFO word.
REQ-002 SHALL have parameter MSB_FIRST, default 1; 1 = shift MSB first, 0 = LSB first.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clock  in  1  sole clock; all state updates on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 en  in  1  serializer enable; sampled only in IDLE and at the byte boundary.
REQ-007 fifo_empty  in  1  upstream FIFO empty flag.
REQ-008 fifo_data  in  DATA_W  upstream FIFO read data, valid the cycle after fifo_read_en.
REQ-009 fifo_read_en  out  1  single-cycle pop request to the FIFO.
REQ-010 bit_out  out  1  serial data bit.
REQ-011 bit_valid  out  1  bit_out holds a valid bit.
REQ-012 bit_ready  in  1  downstream accepts the bit; a transfer occurs when bit_valid && bit_ready.
REQ-013 busy  out  1  high in any state other than IDLE.
REQ-014 byte_done  out  1  one-cycle pulse on the cycle after the final transfer of a byte.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, LOAD, SHIFT, and PARITY (PARITY only with the macro).
REQ-016 IDLE -> REQ when en && !fifo_empty; otherwise SHALL remain in IDLE.
REQ-017 REQ SHALL assert fifo_read_en for exactly one cycle, then go to LOAD.
REQ-018 LOAD SHALL capture fifo_data into the shift register, clear the bit counter, and go to SHIFT.
REQ-019 SHIFT SHALL drive bit_valid=1 and bit_out = current bit (per MSB_FIRST).
REQ-020 On each transfer in SHIFT, SHALL advance the shift register and increment the counter.
REQ-021 bit_out SHALL be held stable while bit_valid && !bit_ready.
REQ-022 The counter SHALL be $clog2(DATA_W)+1 bits wide; on the transfer of bit DATA_W-1, the byte ends.
REQ-023 At byte end, SHALL go to REQ if en && !fifo_empty, else to IDLE; byte_done pulses the next cycle.
REQ-024 With bit_ready tied high, throughput SHALL be DATA_W bits per DATA_W+2 cycles.
REQ-025 SHALL never assert fifo_read_en while fifo_empty is high or outside REQ.
REQ-026 en deasserted mid-byte SHALL NOT abort the byte; the byte completes and the FSM then goes to IDLE.
REQ-027 bit_valid SHALL be 0 in IDLE, REQ, and LOAD.

Reset
REQ-028 On reset: state=IDLE, fifo_read_en=0, bit_valid=0, bit_out=0, busy=0, byte_done=0, shift register and counter = 0.
REQ-029 Reset mid-byte SHALL discard the partial byte with no further pop; output resumes only with the next FIFO word.

Configuration
REQ-030 Macro SERIALIZER_PARITY_EN defined: after the last data bit, PARITY SHALL send one even-parity bit (XOR of the byte) under the same valid/ready rules; byte end moves to that transfer.
REQ-031 Macro undefined: the PARITY state and the parity logic SHALL be absent; SHIFT goes straight to the byte-end decision.

Structure
REQ-032 A shared package SHALL hold the FSM state enum, the default DATA_W, and the counter-width constant.
REQ-033 The shift register plus bit counter SHALL be one sub-module, serializer_shift_reg; the FSM stays in the top.

Verification
REQ-034 FIFO holds 0xA5, en=1, bit_ready=1, MSB_FIRST=1 -> one fifo_read_en pulse, bits 1,0,1,0,0,1,0,1, then byte_done.
REQ-035 FIFO holds 0x3C,0x81 back-to-back, bit_ready=1 -> 16 bits over 20 cycles, exactly two fifo_read_en pulses, no bubble beyond REQ/LOAD.
REQ-036 bit_ready low for 3 cycles on bit 4 of 0xF0 -> bit_out=0 and bit_valid=1 held for 4 cycles; total bit count stays 8.
REQ-037 fifo_empty=1, en=1 for 50 cycles -> fifo_read_en never asserted, busy=0.
REQ-038 Reset pulse after 3 bits of 0xFF, with FIFO then empty -> bit_valid=0 next cycle, no pop, and no bits until a new word arrives.
REQ-039 With SERIALIZER_PARITY_EN, data 0x07 -> 8 data bits then parity bit 1; data 0x03 -> parity bit 0.
